// File: rtl/sd_wfifo_arbiter.sv
// Round-robin burst arbiter sharing the SDRAM write FIFO between blender (0), PCI (1) and RISC (2).
// Grants bursts of up to BURST_LEN words and inserts one idle-select cycle between owners.
module sd_wfifo_arbiter #(
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 4,
    parameter int STAT_W    = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [2:0]        req,
    input  logic [2:0]        req_en,
    input  logic              sd_wfifo_full,
    output logic [1:0]        sd_w_mux_select,
    output logic              sd_wfifo_push_n,
    output logic [2:0]        ack,
    output logic [2:0]        grant,
    output logic              busy,
    output logic [STAT_W-1:0] words_pushed,
    output logic [1:0]        fsm_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        XFER    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [2:0]       grant_d;
    logic [1:0]       rr_ptr, rr_ptr_d;
    logic [CNT_W-1:0] burst_cnt, burst_cnt_d;
    logic [2:0]       eff;
    logic [1:0]       gidx;
    logic [1:0]       win;
    logic             owner_req;
    logic             push;
    logic             last_word;

    assign eff       = req & req_en;
    assign owner_req = |(grant & eff);
    // Push is held off while reset is asserted so an abandoned burst never leaks a word.
    assign push      = sys_rst_n & (state == XFER) & owner_req & ~sd_wfifo_full;
    assign last_word = (burst_cnt == CNT_W'(BURST_LEN - 1));

    assign gidx = grant[2] ? 2'd2 : (grant[1] ? 2'd1 : 2'd0);

    // First requester at or above rr_ptr, wrapping 2 -> 0.
    always_comb begin
        win = 2'd0;
        case (rr_ptr)
            2'd1:    win = eff[1] ? 2'd1 : (eff[2] ? 2'd2 : 2'd0);
            2'd2:    win = eff[2] ? 2'd2 : (eff[0] ? 2'd0 : 2'd1);
            default: win = eff[0] ? 2'd0 : (eff[1] ? 2'd1 : 2'd2);
        endcase
    end

    always_comb begin
        state_d     = state;
        grant_d     = grant;
        rr_ptr_d    = rr_ptr;
        burst_cnt_d = burst_cnt;
        case (state)
            IDLE: begin
                if (|eff) begin
                    state_d     = XFER;
                    grant_d     = 3'b001 << win;
                    burst_cnt_d = '0;
                end
            end
            XFER: begin
                if (!owner_req || (push && last_word)) begin
                    state_d     = RELEASE;
                    grant_d     = '0;
                    burst_cnt_d = '0;
                    rr_ptr_d    = (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
                end else if (push) begin
                    burst_cnt_d = burst_cnt + CNT_W'(1);
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state        <= IDLE;
            grant        <= '0;
            rr_ptr       <= 2'd0;
            burst_cnt    <= '0;
            words_pushed <= '0;
        end else begin
            state        <= state_d;
            grant        <= grant_d;
            rr_ptr       <= rr_ptr_d;
            burst_cnt    <= burst_cnt_d;
            words_pushed <= words_pushed + STAT_W'(push);
        end
    end

    always_comb begin
        sd_w_mux_select = 2'b11;
        if (grant[0])      sd_w_mux_select = 2'b00;
        else if (grant[1]) sd_w_mux_select = 2'b01;
        else if (grant[2]) sd_w_mux_select = 2'b10;
    end

    assign sd_wfifo_push_n = ~push;
    assign ack             = push ? grant : 3'b000;
    assign busy            = (state != IDLE);
    assign fsm_state       = state;

endmodule

// File: tb/tb_sd_wfifo_arbiter.sv
// Directed bench for sd_wfifo_arbiter: expected pushes are queued by the stimulus and
// popped by a negedge monitor; a second small-STAT_W instance exercises counter wrap.
module tb_sd_wfifo_arbiter;

    localparam int W = 5;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [2:0]  req;
    logic [2:0]  req_en;
    logic        sd_wfifo_full;
    logic [1:0]  sd_w_mux_select;
    logic        sd_wfifo_push_n;
    logic [2:0]  ack;
    logic [2:0]  grant;
    logic        busy;
    logic [15:0] words_pushed;
    logic [1:0]  fsm_state;

    logic        w_rst_n;
    logic [2:0]  w_req;
    logic [2:0]  w_req_en;
    logic        w_full;
    logic [1:0]  w_select;
    logic        w_push_n;
    logic [2:0]  w_ack;
    logic [2:0]  w_grant;
    logic        w_busy;
    logic [3:0]  w_words;
    logic [1:0]  w_state;

    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;
    int           w_cnt    = 0;
    bit           mon_en   = 0;

    sd_wfifo_arbiter #(.BURST_LEN(4), .CNT_W(4), .STAT_W(16)) u_dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .req            (req),
        .req_en         (req_en),
        .sd_wfifo_full  (sd_wfifo_full),
        .sd_w_mux_select(sd_w_mux_select),
        .sd_wfifo_push_n(sd_wfifo_push_n),
        .ack            (ack),
        .grant          (grant),
        .busy           (busy),
        .words_pushed   (words_pushed),
        .fsm_state      (fsm_state)
    );

    sd_wfifo_arbiter #(.BURST_LEN(4), .CNT_W(4), .STAT_W(4)) u_wrap (
        .sys_clk        (sys_clk),
        .sys_rst_n      (w_rst_n),
        .req            (w_req),
        .req_en         (w_req_en),
        .sd_wfifo_full  (w_full),
        .sd_w_mux_select(w_select),
        .sd_wfifo_push_n(w_push_n),
        .ack            (w_ack),
        .grant          (w_grant),
        .busy           (w_busy),
        .words_pushed   (w_words),
        .fsm_state      (w_state)
    );

    // clock / reset
    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_burst(input logic [1:0] sel, input logic [2:0] a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back({sel, a});
    endtask

    // monitor / scoreboard
    always @(negedge sys_clk) begin
        if (mon_en) begin
            if (!sd_wfifo_push_n) begin
                check("push_while_busy", {31'd0, busy}, 32'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_push: got sel=%0d ack=%b expected no push",
                             sd_w_mux_select, ack);
                end else begin
                    check("push_word", {27'd0, sd_w_mux_select, ack}, {27'd0, exp_q.pop_front()});
                end
            end else begin
                check("idle_ack", {29'd0, ack}, 32'd0);
            end
            if (grant == 3'b000) check("idle_select", {30'd0, sd_w_mux_select}, 32'd3);
        end
    end

    always @(negedge sys_clk) begin
        if (w_rst_n && !w_push_n) w_cnt++;
    end

    logic [1:0] rr_sel[4];
    logic [2:0] rr_grant[4];
    bit         seen15;

    initial begin
        rr_sel   = '{2'b00, 2'b01, 2'b10, 2'b00};
        rr_grant = '{3'b001, 3'b010, 3'b100, 3'b001};
        seen15   = 0;

        // reset with all producers requesting
        sys_rst_n = 0; req = 3'b111; req_en = 3'b111; sd_wfifo_full = 0;
        w_rst_n = 0; w_req = 3'b001; w_req_en = 3'b111; w_full = 0;
        tick();
        mon_en = 1;
        tick();
        check("rst_grant", {29'd0, grant}, 32'd0);
        check("rst_select", {30'd0, sd_w_mux_select}, 32'd3);
        check("rst_push_n", {31'd0, sd_wfifo_push_n}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_words", {16'd0, words_pushed}, 32'd0);

        // single producer: one full burst then a regrant
        sys_rst_n = 1; req = 3'b010;
        expect_burst(2'b01, 3'b010, 4);
        tick();
        check("single_grant", {29'd0, grant}, 32'h2);
        check("single_select", {30'd0, sd_w_mux_select}, 32'd1);
        repeat (4) tick();
        check("single_release_grant", {29'd0, grant}, 32'd0);
        check("single_release_busy", {31'd0, busy}, 32'd1);
        check("single_all_pushed", exp_q.size(), 32'd0);
        tick();
        check("single_idle_busy", {31'd0, busy}, 32'd0);
        check("single_words", {16'd0, words_pushed}, 32'd4);
        tick();
        check("single_regrant", {29'd0, grant}, 32'h2);
        req = 3'b000;
        tick();
        check("drop0_release", {29'd0, grant}, 32'd0);
        tick();
        check("drop0_words", {16'd0, words_pushed}, 32'd4);

        // reset in the middle of a risc burst
        req = 3'b111;
        expect_burst(2'b10, 3'b100, 1);
        tick();
        check("mid_grant", {29'd0, grant}, 32'h4);
        tick();
        sys_rst_n = 0;
        tick();
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_grant", {29'd0, grant}, 32'd0);
        check("mid_rst_words", {16'd0, words_pushed}, 32'd0);
        check("mid_rst_pushes", exp_q.size(), 32'd0);
        sys_rst_n = 1;

        // round robin with all requests held
        for (int k = 0; k < 4; k++) begin
            expect_burst(rr_sel[k], rr_grant[k], 4);
            tick();
            check("rr_grant", {29'd0, grant}, {29'd0, rr_grant[k]});
            check("rr_select", {30'd0, sd_w_mux_select}, {30'd0, rr_sel[k]});
            repeat (4) tick();
            check("rr_release_grant", {29'd0, grant}, 32'd0);
            check("rr_release_select", {30'd0, sd_w_mux_select}, 32'd3);
            if (k == 3) req = 3'b000;
            tick();
            check("rr_idle_busy", {31'd0, busy}, 32'd0);
        end
        check("rr_words", {16'd0, words_pushed}, 32'd16);
        check("rr_all_pushed", exp_q.size(), 32'd0);

        // backpressure on a pci burst
        req = 3'b010;
        expect_burst(2'b01, 3'b010, 4);
        tick();
        check("bp_grant", {29'd0, grant}, 32'h2);
        tick();
        sd_wfifo_full = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("bp_hold_grant", {29'd0, grant}, 32'h2);
        end
        sd_wfifo_full = 0;
        repeat (2) begin
            tick();
            check("bp_drain_grant", {29'd0, grant}, 32'h2);
        end
        tick();
        check("bp_release", {29'd0, grant}, 32'd0);
        req = 3'b000;
        tick();
        check("bp_words", {16'd0, words_pushed}, 32'd20);
        check("bp_all_pushed", exp_q.size(), 32'd0);

        // risc drops after two words
        req = 3'b100;
        expect_burst(2'b10, 3'b100, 2);
        tick();
        check("drop_grant", {29'd0, grant}, 32'h4);
        repeat (2) tick();
        req = 3'b000;
        tick();
        check("drop_release", {29'd0, grant}, 32'd0);
        check("drop_words", {16'd0, words_pushed}, 32'd22);
        tick();

        // rr_ptr back at blender: blender beats pci
        req = 3'b011;
        tick();
        check("ptr_after_risc", {29'd0, grant}, 32'h1);
        req = 3'b000;
        repeat (2) tick();

        // masked blender is never granted
        req_en = 3'b110; req = 3'b001;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("mask_busy", {31'd0, busy}, 32'd0);
            check("mask_grant", {29'd0, grant}, 32'd0);
        end
        req = 3'b000; req_en = 3'b111;

        // statistic wrap on the 4-bit instance
        w_rst_n = 1;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (w_cnt == 15 && !seen15) begin
                seen15 = 1;
                check("wrap_words15", {28'd0, w_words}, 32'd15);
            end
            if (w_cnt >= 16) break;
        end
        check("wrap_push_count", w_cnt, 32'd16);
        check("wrap_words0", {28'd0, w_words}, 32'd0);
        w_req = 3'b000;

        tick();
        check("final_all_pushed", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
